// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle LEGv8 sequencing controller
//
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Memory
// accesses stall on mem_ready. Illegal opcodes and memory timeouts trap
// into FAULT, which is left only through reset.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   instr_opcode      ins[31:21], latched when ir_write=1
//   mem_ready         current fetch/data access completes this cycle
//   alu_zero          ALU zero flag, used by CBZ in EXEC
//   imem_read, ir_write, pc_write, pc_src            fetch / PC strobes
//   reg2loc, alusrc, memtoreg, regwrite, dmem_read,
//   dmem_write, aluop                                datapath controls
//   state             FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 FAULT=7
//   fault             high while in FAULT
//   retired           instructions completed since reset (wrapping)
module multicycle_control #(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      instr_opcode,
  input  logic             mem_ready,
  input  logic             alu_zero,
  output logic             imem_read,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg2loc,
  output logic             alusrc,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [1:0]       aluop,
  output logic [2:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {C_R, C_LD, C_ST, C_CBZ, C_B, C_ILL} class_t;

  // Last stalled cycle still tolerated; one more miss traps.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  state_t      cur;
  class_t      cls;
  logic [10:0] opcode_q;
  logic [7:0]  wait_cnt;

  always_comb begin
    cls = C_ILL;
    casez (opcode_q)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: cls = C_R;
      11'b11111000010: cls = C_LD;
      11'b11111000000: cls = C_ST;
      11'b10110100???: cls = C_CBZ;
      11'b000101?????: cls = C_B;
      default:         cls = C_ILL;
    endcase
  end

  // wait_cnt defaults to clear so any state change restarts the stall count;
  // only the stay-and-wait branches override it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= S_FETCH;
      opcode_q <= '0;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      wait_cnt <= '0;
      case (cur)
        S_FETCH: begin
          if (mem_ready) begin
            opcode_q <= instr_opcode;
            cur      <= S_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            cur <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DECODE: cur <= (cls == C_ILL) ? S_FAULT : S_EXEC;
        S_EXEC: begin
          case (cls)
            C_R:        cur <= S_WB;
            C_LD, C_ST: cur <= S_MEM;
            C_CBZ, C_B: begin
              cur     <= S_FETCH;
              retired <= retired + CNT_W'(1);
            end
            default:    cur <= S_FAULT;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (cls == C_LD) begin
              cur <= S_WB;
            end else begin
              cur     <= S_FETCH;
              retired <= retired + CNT_W'(1);
            end
          end else if (wait_cnt == WAIT_LAST) begin
            cur <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB: begin
          cur     <= S_FETCH;
          retired <= retired + CNT_W'(1);
        end
        S_FAULT: cur <= S_FAULT;
        default: cur <= S_FAULT;
      endcase
    end
  end

  // Strobes are decoded straight from state so they follow mem_ready and
  // alu_zero in the same cycle; reset gates them off to abort cleanly.
  always_comb begin
    imem_read  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg2loc    = 1'b0;
    alusrc     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    aluop      = 2'b00;
    if (!reset) begin
      case (cur)
        S_FETCH: begin
          imem_read = 1'b1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: reg2loc = (cls == C_ST) || (cls == C_CBZ);
        S_EXEC: begin
          case (cls)
            C_R: aluop = 2'b10;
            C_LD, C_ST: alusrc = 1'b1;
            C_CBZ: begin
              aluop    = 2'b01;
              reg2loc  = 1'b1;
              pc_src   = 1'b1;
              pc_write = alu_zero;
            end
            C_B: begin
              pc_src   = 1'b1;
              pc_write = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          alusrc     = 1'b1;
          dmem_read  = (cls == C_LD);
          dmem_write = (cls == C_ST);
        end
        S_WB: begin
          regwrite = 1'b1;
          memtoreg = (cls == C_LD);
        end
        default: ;
      endcase
    end
  end

  assign state = cur;
  assign fault = (cur == S_FAULT);

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam int CW = 4;
  localparam int WL = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   instr_opcode;
  logic          mem_ready, alu_zero;
  logic          imem_read, ir_write, pc_write, pc_src, reg2loc, alusrc;
  logic          memtoreg, regwrite, dmem_read, dmem_write, fault;
  logic [1:0]    aluop;
  logic [2:0]    state;
  logic [CW-1:0] retired;
  logic [12:0]   ctl;

  multicycle_control #(.CNT_W(CW), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset), .instr_opcode(instr_opcode),
    .mem_ready(mem_ready), .alu_zero(alu_zero),
    .imem_read(imem_read), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg2loc(reg2loc), .alusrc(alusrc),
    .memtoreg(memtoreg), .regwrite(regwrite), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .aluop(aluop), .state(state),
    .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  assign ctl = {imem_read, ir_write, pc_write, pc_src, reg2loc, alusrc,
                memtoreg, regwrite, dmem_read, dmem_write, aluop, fault};

  localparam logic [12:0] IMR = 13'h1000, IRW = 13'h0800, PCW = 13'h0400,
                          PCS = 13'h0200, R2L = 13'h0100, ASR = 13'h0080,
                          M2R = 13'h0040, RGW = 13'h0020, DRD = 13'h0010,
                          DWR = 13'h0008, AOP_CBZ = 13'h0002, AOP_R = 13'h0004,
                          FLT = 13'h0001;

  typedef enum int {K_R, K_LD, K_ST, K_CBZ, K_B, K_ILL} kind_t;

  typedef struct {
    logic [2:0]  st;
    logic        rdy;
    logic        z;
    logic [12:0] ctl;
    bit          ret;
  } cyc_t;

  cyc_t plan[$];
  int   total = 0;
  int   bad = 0;
  int   model_retired = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic kind_t classify(input logic [10:0] op);
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return K_R;
    if (op == 11'b11111000010) return K_LD;
    if (op == 11'b11111000000) return K_ST;
    if (op[10:3] == 8'b10110100) return K_CBZ;
    if (op[10:5] == 6'b000101) return K_B;
    return K_ILL;
  endfunction

  function automatic logic [10:0] pick_op(input kind_t k);
    logic [10:0] rtab [4];
    logic [10:0] op;
    rtab = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    case (k)
      K_R:   op = rtab[$urandom % 4];
      K_LD:  op = 11'b11111000010;
      K_ST:  op = 11'b11111000000;
      K_CBZ: op = {8'b10110100, 3'($urandom)};
      K_B:   op = {6'b000101, 5'($urandom)};
      default: begin
        op = 11'($urandom);
        while (classify(op) != K_ILL) op = 11'($urandom);
      end
    endcase
    return op;
  endfunction

  task automatic push(input logic [2:0] st, input logic rdy, input logic z,
                      input logic [12:0] c, input bit ret);
    plan.push_back('{st, rdy, z, c, ret});
  endtask

  function automatic logic rb();
    return 1'($urandom & 1);
  endfunction

  task automatic push_fault(input int n);
    for (int k = 0; k < n; k++) push(3'd7, rb(), rb(), FLT, 1'b0);
  endtask

  // Expands one instruction into its expected cycle-by-cycle trace.
  task automatic build(input logic [10:0] op, input int fstall, input int mstall, input logic z);
    kind_t       k;
    logic [12:0] m;
    k = classify(op);
    plan.delete();
    for (int i = 0; i < fstall && i < WL; i++) push(3'd0, 1'b0, rb(), IMR, 1'b0);
    if (fstall >= WL) begin push_fault(8); return; end
    push(3'd0, 1'b1, rb(), IMR | IRW | PCW, 1'b0);
    push(3'd1, rb(), rb(), (k == K_ST || k == K_CBZ) ? R2L : 13'h0, 1'b0);
    case (k)
      K_ILL: push_fault(10);
      K_R: begin
        push(3'd2, rb(), rb(), AOP_R, 1'b0);
        push(3'd4, rb(), rb(), RGW, 1'b1);
      end
      K_CBZ: push(3'd2, rb(), z, AOP_CBZ | R2L | PCS | (z ? PCW : 13'h0), 1'b1);
      K_B:   push(3'd2, rb(), rb(), PCS | PCW, 1'b1);
      default: begin
        m = (k == K_LD) ? DRD : DWR;
        push(3'd2, rb(), rb(), ASR, 1'b0);
        for (int i = 0; i < mstall && i < WL; i++) push(3'd3, 1'b0, rb(), ASR | m, 1'b0);
        if (mstall >= WL) begin push_fault(8); return; end
        push(3'd3, 1'b1, rb(), ASR | m, k == K_ST);
        if (k == K_LD) push(3'd4, rb(), rb(), RGW | M2R, 1'b1);
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = rb();
    alu_zero = rb();
    #1;
    chk("rst_strobes", 32'(ctl & ~FLT), 32'h0);
    model_retired = 0;
  endtask

  // Drives the trace; rst_at selects a cycle in which reset aborts it.
  task automatic exec(input logic [10:0] op, input int rst_at);
    for (int i = 0; i < plan.size(); i++) begin
      @(negedge clk);
      reset = (i == rst_at);
      mem_ready = plan[i].rdy;
      alu_zero = plan[i].z;
      instr_opcode = (plan[i].st == 3'd0 && plan[i].rdy) ? op : 11'($urandom);
      #1;
      chk("state", 32'(state), 32'(plan[i].st));
      chk("retired", 32'(retired), 32'(model_retired % (1 << CW)));
      if (i == rst_at) begin
        chk("abort_strobes", 32'(ctl & ~FLT), 32'h0);
        model_retired = 0;
        return;
      end
      chk("ctl", 32'(ctl), 32'(plan[i].ctl));
      if (plan[i].ret) model_retired++;
    end
    if (plan[plan.size()-1].st == 3'd7) do_reset();
  endtask

  task automatic run(input logic [10:0] op, input int fstall, input int mstall,
                     input logic z, input int rst_at);
    build(op, fstall, mstall, z);
    exec(op, rst_at);
  endtask

  initial begin
    kind_t k;
    logic [10:0] op;
    int fs, ms, ra;
    reset = 1'b1;
    mem_ready = 1'b0;
    alu_zero = 1'b0;
    instr_opcode = 11'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 32'(state), 32'h0);
    chk("reset_retired", 32'(retired), 32'h0);
    chk("reset_strobes", 32'(ctl), 32'h0);

    run(11'b10001011000, 0, 0, 1'b0, -1);           // ADD
    run(11'b11111000010, 0, 3, 1'b0, -1);           // LDUR, 3 MEM stalls
    run(11'b10110100101, 0, 0, 1'b0, -1);           // CBZ not taken
    run(11'b10110100010, 0, 0, 1'b1, -1);           // CBZ taken
    run(11'b11111111111, 0, 0, 1'b0, -1);           // illegal
    run(11'b10001011000, 15, 0, 1'b0, -1);          // fetch timeout
    run(11'b10101010000, 14, 0, 1'b0, -1);          // ready on last allowed cycle
    run(11'b11111000010, 0, 15, 1'b0, -1);          // MEM timeout
    run(11'b11111000010, 0, 14, 1'b0, -1);
    run(11'b11111000000, 0, 2, 1'b0, 4);            // STUR aborted in MEM
    do_reset();
    for (int n = 0; n < 16; n++) run(pick_op(K_B), 0, 0, 1'b0, -1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("wrap", 32'(retired), 32'h0);
    do_reset();

    for (int n = 0; n < 80; n++) begin
      k = kind_t'($urandom % 6);
      op = pick_op(k);
      fs = ($urandom % 8 == 0) ? 14 + ($urandom % 2) : $urandom % 3;
      ms = ($urandom % 8 == 0) ? 14 + ($urandom % 2) : $urandom % 4;
      build(op, fs, ms, rb());
      ra = ($urandom % 10 == 0) ? int'($urandom % plan.size()) : -1;
      exec(op, ra);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("final_retired", 32'(retired), 32'(model_retired % (1 << CW)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
